decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 and 64 are legal.
REQ-002 SHALL have parameter DEPTH, default 2, output queue entries; legal range is 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset; asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit: discards all queued and incoming instructions.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_inst (input, 32) and in_pc (input, XLEN).
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1).
REQ-008 SHALL have out_pc (XLEN), out_opcode (7), out_rd (5), out_rs1 (5), out_rs2 (5), out_funct3 (3), out_funct7 (7) and out_shamt (6), all outputs.
REQ-009 SHALL have out_imm (XLEN) and out_type (3), both outputs.
REQ-010 SHALL have 1-bit outputs out_is_load, out_is_store, out_is_writeback, out_use_adder, out_use_pc, out_is_lui, out_is_system, out_is_illegal and out_is_muldiv.

Function
REQ-011 SHALL accept an instruction on a clk edge where in_valid && in_ready && !flush.
REQ-012 SHALL drive in_ready = (count < DEPTH), with no same-cycle pass-through when the queue is full.
REQ-013 SHALL present an accepted instruction on the out_* ports one cycle after acceptance if the queue was empty; minimum latency is 1.
REQ-014 SHALL pop the head entry when out_valid && out_ready; out_* fields SHALL stay stable while out_valid && !out_ready.
REQ-015 SHALL support simultaneous push and pop: count is unchanged and order is preserved (FIFO, circular pointers wrapping at DEPTH-1 -> 0).
REQ-016 SHALL, when flush is high, set count to 0 and out_valid to 0 on the next edge, ignoring any push or pop in that cycle.
REQ-017 SHALL sign-extend immediates from inst[31] to XLEN, by type:
- I/JR: inst[31:20]
- S: {inst[31:25], inst[11:7]}
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
- U: {inst[31:12], 12'b0}
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- R: 0
REQ-018 SHALL drive out_rs2 = inst[24:20] for R, S and B types, and 0 otherwise.
REQ-019 SHALL drive out_shamt = inst[25:20] when XLEN=64, and {1'b0, inst[24:20]} when XLEN=32.
REQ-020 SHALL force out_is_writeback to 0 when rd==0.
REQ-021 SHALL set out_use_pc for AUIPC, JAL and JALR; out_is_lui for LUI only.
REQ-022 SHALL set out_is_illegal, and clear out_is_load, out_is_store and out_is_writeback, when any of these hold:
- inst[1:0] != 2'b11
- unknown opcode
- OP with funct7 not in {0x00, 0x20}
- funct7=0x20 on OP with funct3 not in {000, 101}
- OP_IMM shift whose upper funct bits are illegal for XLEN
REQ-023 SHALL still enqueue and present illegal instructions in order; illegality is reported, not dropped.

Reset
REQ-024 SHALL, while rst_n is low, clear count and pointers and drive out_valid=0 and in_ready=0, with all out_* fields reading 0.
REQ-025 SHALL drive in_ready=1 from the first edge after rst_n deasserts; assertion mid-transfer SHALL lose queued entries without X propagation.

Configuration
REQ-026 SHALL recognise macro DECODE_STAGE_RV_M_EN.
REQ-027 With DECODE_STAGE_RV_M_EN defined, OP with funct7=0x01 SHALL be legal, with out_is_muldiv=1 and out_is_writeback=(rd!=0).
REQ-028 Without DECODE_STAGE_RV_M_EN, OP with funct7=0x01 SHALL be illegal, and out_is_muldiv SHALL be tied 0.

Structure
REQ-029 SHALL take the following from shared package decode_pkg:
- opcode constants (LUI, AUIPC, OP, OP_IMM, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM)
- TYPE_R/I/JR/S/B/U/J 3-bit encodings
- the decoded-record struct typedef
REQ-030 SHALL instantiate one combinational sub-module, decode_core (inst -> decoded record, parameter XLEN); the FIFO and handshake SHALL stay in decode_stage.

Verification
REQ-031 SHALL verify: in_inst=0x00500093 accepted, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, is_writeback=1, is_illegal=0.
REQ-032 SHALL verify: 0x0020A423 -> is_store=1, rs1=1, rs2=2, imm=8, is_writeback=0; then 0xFE000EE3 -> type B, imm=0xFFFFFFFC (XLEN=32) / 0xFFFFFFFFFFFFFFFC (XLEN=64).
REQ-033 SHALL verify: 0x022081B3 -> with DECODE_STAGE_RV_M_EN, is_muldiv=1, is_illegal=0, rd=3; without it, is_illegal=1, is_writeback=0.
REQ-034 SHALL verify: DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready=0 after the 2nd; the third is held; with out_ready=1, the output order is 1, 2, 3.
REQ-035 SHALL verify: queue holding 2 entries, flush pulsed 1 cycle with in_valid=1 -> next cycle out_valid=0, count=0, and the flushed input never appears.
REQ-036 SHALL verify: rst_n dropped asynchronously mid-stream -> out_valid=0 immediately; after release, 0x00000013 flows with 1-cycle latency.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: RV opcode constants, instruction-format
// encodings and the decoded-instruction record carried through the queue.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] TYPE_R  = 3'd0;
    localparam logic [2:0] TYPE_I  = 3'd1;
    localparam logic [2:0] TYPE_JR = 3'd2;
    localparam logic [2:0] TYPE_S  = 3'd3;
    localparam logic [2:0] TYPE_B  = 3'd4;
    localparam logic [2:0] TYPE_U  = 3'd5;
    localparam logic [2:0] TYPE_J  = 3'd6;

    // Immediate is always built at the widest legal XLEN; consumers truncate.
    localparam int IMM_W = 64;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [5:0]       shamt;
        logic [IMM_W-1:0] imm;
        logic [2:0]       itype;
        logic             is_load;
        logic             is_store;
        logic             is_writeback;
        logic             use_adder;
        logic             use_pc;
        logic             is_lui;
        logic             is_system;
        logic             is_illegal;
        logic             is_muldiv;
    } decoded_t;

endpackage

// File: rtl/decode_core.sv
// Combinational RV instruction decoder: raw 32-bit instruction -> decoded_t.
// Optional M-extension legality is enabled by macro DECODE_STAGE_RV_M_EN.
module decode_core
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] inst,
    output decoded_t    dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] itype;
    logic       known;
    logic       bad;
    logic       wb;
    logic       ld;
    logic       st;
    logic       muldiv;
    logic       illegal;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Classify the opcode, check legality, then assemble the decoded record.
    always_comb begin
        dec     = '0;
        itype   = TYPE_R;
        known   = 1'b1;
        bad     = 1'b0;
        wb      = 1'b0;
        ld      = 1'b0;
        st      = 1'b0;
        muldiv  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI:      begin itype = TYPE_U; wb = 1'b1; dec.is_lui = 1'b1; end
            OPC_AUIPC:    begin itype = TYPE_U; wb = 1'b1; dec.use_pc = 1'b1; dec.use_adder = 1'b1; end
            OPC_JAL:      begin itype = TYPE_J; wb = 1'b1; dec.use_pc = 1'b1; dec.use_adder = 1'b1; end
            OPC_JALR:     begin itype = TYPE_JR; wb = 1'b1; dec.use_pc = 1'b1; dec.use_adder = 1'b1; end
            OPC_BRANCH:   itype = TYPE_B;
            OPC_LOAD:     begin itype = TYPE_I; wb = 1'b1; ld = 1'b1; dec.use_adder = 1'b1; end
            OPC_STORE:    begin itype = TYPE_S; st = 1'b1; dec.use_adder = 1'b1; end
            OPC_MISC_MEM: itype = TYPE_I;
            OPC_SYSTEM:   begin itype = TYPE_I; wb = (funct3 != 3'b000); dec.is_system = 1'b1; end
            OPC_OP: begin
                itype = TYPE_R;
                wb    = 1'b1;
                case (funct7)
                    7'h00: bad = 1'b0;
                    7'h20: bad = !(funct3 == 3'b000 || funct3 == 3'b101);
`ifdef DECODE_STAGE_RV_M_EN
                    7'h01: muldiv = 1'b1;
`endif
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                itype = TYPE_I;
                wb    = 1'b1;
                // Shifts reuse the upper immediate bits as funct bits; the
                // shamt width (5 or 6 bits) depends on XLEN.
                if (funct3 == 3'b001) begin
                    bad = (XLEN == 64) ? (inst[31:26] != 6'b000000) : (inst[31:25] != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    bad = (XLEN == 64) ? !(inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000)
                                       : !(inst[31:25] == 7'b0000000 || inst[31:25] == 7'b0100000);
                end
            end
            default: known = 1'b0;
        endcase

        illegal = (inst[1:0] != 2'b11) || !known || bad;

        case (itype)
            TYPE_I, TYPE_JR: dec.imm = {{52{inst[31]}}, inst[31:20]};
            TYPE_S:          dec.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_B:          dec.imm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            TYPE_U:          dec.imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            TYPE_J:          dec.imm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default:         dec.imm = '0;
        endcase

        dec.opcode       = opcode;
        dec.rd           = (itype == TYPE_S || itype == TYPE_B) ? 5'd0 : inst[11:7];
        dec.rs1          = (itype == TYPE_U || itype == TYPE_J) ? 5'd0 : inst[19:15];
        dec.rs2          = (itype == TYPE_R || itype == TYPE_S || itype == TYPE_B) ? inst[24:20] : 5'd0;
        dec.funct3       = funct3;
        dec.funct7       = funct7;
        dec.shamt        = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
        dec.itype        = itype;
        dec.is_illegal   = illegal;
        dec.is_load      = ld && !illegal;
        dec.is_store     = st && !illegal;
        dec.is_writeback = wb && !illegal && (inst[11:7] != 5'd0);
        dec.is_muldiv    = muldiv && !illegal;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes incoming instructions and buffers the decoded records
// in a DEPTH-entry FIFO towards the next stage. Optional macro:
// DECODE_STAGE_RV_M_EN (accept RV M-extension ops as legal).
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [5:0]      out_shamt,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_writeback,
    output logic            out_use_adder,
    output logic            out_use_pc,
    output logic            out_is_lui,
    output logic            out_is_system,
    output logic            out_is_illegal,
    output logic            out_is_muldiv
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    decoded_t        in_dec;
    decoded_t        head;
    decoded_t        mem_dec [DEPTH];
    logic [XLEN-1:0] mem_pc  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic            ready_en;
    logic            push;
    logic            pop;
    logic            unused_head_imm;

    decode_core #(.XLEN(XLEN)) u_core (
        .inst (in_inst),
        .dec  (in_dec)
    );

    // Handshake: a transfer happens on a clock edge where valid && ready are
    // both high. A producer holding valid keeps its payload stable until the
    // transfer; ready never depends on valid in the same cycle. Flush wins
    // over both sides, so no transfer completes in a flush cycle.
    assign in_ready  = ready_en && (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queue bookkeeping: occupancy, circular pointers and post-reset ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage; cleared on reset so every output field reads zero then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_dec[i] <= '0;
                mem_pc[i]  <= '0;
            end
        end else if (push) begin
            mem_dec[wr_ptr] <= in_dec;
            mem_pc[wr_ptr]  <= in_pc;
        end
    end

    assign head            = mem_dec[rd_ptr];
    // Upper immediate bits beyond XLEN are intentionally dropped.
    assign unused_head_imm = ^head.imm;

    assign out_pc           = mem_pc[rd_ptr];
    assign out_opcode       = head.opcode;
    assign out_rd           = head.rd;
    assign out_rs1          = head.rs1;
    assign out_rs2          = head.rs2;
    assign out_funct3       = head.funct3;
    assign out_funct7       = head.funct7;
    assign out_shamt        = head.shamt;
    assign out_imm          = head.imm[XLEN-1:0];
    assign out_type         = head.itype;
    assign out_is_load      = head.is_load;
    assign out_is_store     = head.is_store;
    assign out_is_writeback = head.is_writeback;
    assign out_use_adder    = head.use_adder;
    assign out_use_pc       = head.use_pc;
    assign out_is_lui       = head.is_lui;
    assign out_is_system    = head.is_system;
    assign out_is_illegal   = head.is_illegal;
    assign out_is_muldiv    = head.is_muldiv;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (XLEN=32, DEPTH=2). Honours
// DECODE_STAGE_RV_M_EN for the mul/div expectations.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [5:0]      out_shamt;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic out_is_load, out_is_store, out_is_writeback, out_use_adder, out_use_pc;
    logic out_is_lui, out_is_system, out_is_illegal, out_is_muldiv;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_type(out_type),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_writeback(out_is_writeback), .out_use_adder(out_use_adder),
        .out_use_pc(out_use_pc), .out_is_lui(out_is_lui), .out_is_system(out_is_system),
        .out_is_illegal(out_is_illegal), .out_is_muldiv(out_is_muldiv)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_pc !== '0 || out_imm !== '0) begin failures++; $display("FAIL rst_fields pc=%h imm=%h exp=0", out_pc, out_imm); end
        checks++; if (out_is_illegal !== 1'b0 || out_type !== 3'd0) begin failures++; $display("FAIL rst_flags ill=%b type=%0d exp=0", out_is_illegal, out_type); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_addi;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
        checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin failures++; $display("FAIL addi_regs rd=%0d rs1=%0d exp=1,0", out_rd, out_rs1); end
        checks++; if (out_imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", out_imm); end
        checks++; if (out_is_writeback !== 1'b1 || out_is_illegal !== 1'b0) begin failures++; $display("FAIL addi_flags wb=%b ill=%b exp=1,0", out_is_writeback, out_is_illegal); end
        checks++; if (out_pc !== 32'h100 || out_type !== TYPE_I) begin failures++; $display("FAIL addi_pc_type pc=%h type=%0d exp=100,%0d", out_pc, out_type, TYPE_I); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_store_branch;
        logic [XLEN-1:0] exp_imm;
        exp_imm = '1; exp_imm[1:0] = 2'b00;
        in_valid = 1'b1; in_inst = 32'h0020A423; in_pc = 32'h200; out_ready = 1'b1;
        @(negedge clk);
        in_inst = 32'hFE000EE3; in_pc = 32'h204;
        checks++; if (out_is_store !== 1'b1 || out_is_writeback !== 1'b0) begin failures++; $display("FAIL sw_flags st=%b wb=%b exp=1,0", out_is_store, out_is_writeback); end
        checks++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin failures++; $display("FAIL sw_regs rs1=%0d rs2=%0d exp=1,2", out_rs1, out_rs2); end
        checks++; if (out_imm !== 32'd8 || out_type !== TYPE_S) begin failures++; $display("FAIL sw_imm imm=%h type=%0d exp=8,%0d", out_imm, out_type, TYPE_S); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin failures++; $display("FAIL br_pc v=%b pc=%h exp=1,204", out_valid, out_pc); end
        checks++; if (out_type !== TYPE_B || out_imm !== exp_imm) begin failures++; $display("FAIL br_imm type=%0d imm=%h exp=%0d,%h", out_type, out_imm, TYPE_B, exp_imm); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL br_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_upper_jump;
        in_valid = 1'b1; in_inst = 32'h123450B7; in_pc = 32'h240; out_ready = 1'b1;
        @(negedge clk);
        in_inst = 32'h008000EF; in_pc = 32'h244;
        checks++; if (out_is_lui !== 1'b1 || out_use_pc !== 1'b0 || out_imm !== 32'h12345000) begin failures++; $display("FAIL lui lui=%b pc=%b imm=%h exp=1,0,12345000", out_is_lui, out_use_pc, out_imm); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_use_pc !== 1'b1 || out_is_lui !== 1'b0 || out_imm !== 32'd8 || out_type !== TYPE_J) begin failures++; $display("FAIL jal pc=%b lui=%b imm=%h type=%0d exp=1,0,8,%0d", out_use_pc, out_is_lui, out_imm, out_type, TYPE_J); end
        checks++; if (out_is_writeback !== 1'b1 || out_rd !== 5'd1) begin failures++; $display("FAIL jal_wb wb=%b rd=%0d exp=1,1", out_is_writeback, out_rd); end
        @(negedge clk);
    endtask

    task automatic test_muldiv;
        in_valid = 1'b1; in_inst = 32'h022081B3; in_pc = 32'h280; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3) begin failures++; $display("FAIL mul_rd v=%b rd=%0d exp=1,3", out_valid, out_rd); end
`ifdef DECODE_STAGE_RV_M_EN
        checks++; if (out_is_muldiv !== 1'b1 || out_is_illegal !== 1'b0 || out_is_writeback !== 1'b1) begin failures++; $display("FAIL mul_flags md=%b ill=%b wb=%b exp=1,0,1", out_is_muldiv, out_is_illegal, out_is_writeback); end
`else
        checks++; if (out_is_muldiv !== 1'b0 || out_is_illegal !== 1'b1 || out_is_writeback !== 1'b0) begin failures++; $display("FAIL mul_flags md=%b ill=%b wb=%b exp=0,1,0", out_is_muldiv, out_is_illegal, out_is_writeback); end
`endif
        @(negedge clk);
    endtask

    task automatic test_illegal;
        logic [31:0] insts [5];
        logic        exp_ill [5];
        insts[0] = 32'h00000000; exp_ill[0] = 1'b1;        // low bits != 11
        insts[1] = 32'h0000007F; exp_ill[1] = 1'b1;        // unknown opcode
        insts[2] = 32'h40001033; exp_ill[2] = 1'b1;        // funct7=0x20 with funct3=001
        insts[3] = 32'h02009093; exp_ill[3] = (XLEN == 32); // slli by 32
        insts[4] = 32'h40005033; exp_ill[4] = 1'b0;        // sra, legal
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_inst = insts[i]; in_pc = XLEN'(32'h300 + 4 * i);
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_is_illegal !== exp_ill[i]) begin failures++; $display("FAIL illegal_%0d v=%b ill=%b exp=1,%b", i, out_valid, out_is_illegal, exp_ill[i]); end
            checks++; if (out_is_writeback !== 1'b0 || out_is_load !== 1'b0 || out_is_store !== 1'b0) begin failures++; $display("FAIL illegal_flags_%0d wb=%b ld=%b st=%b exp=0", i, out_is_writeback, out_is_load, out_is_store); end
            if (i == 3) begin
                checks++; if (out_shamt !== ((XLEN == 64) ? 6'd32 : 6'd0)) begin failures++; $display("FAIL slli_shamt got=%0d", out_shamt); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [XLEN-1:0] got;
        bit pending;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h1000; exp_q.push_back(32'h1000);
        @(negedge clk);
        in_inst = 32'h00200113; in_pc = 32'h2000; exp_q.push_back(32'h2000);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
        in_inst = 32'h00300193; in_pc = 32'h3000; exp_q.push_back(32'h3000);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_pc !== 32'h1000) begin failures++; $display("FAIL b2b_hold ready=%b pc=%h exp=0,1000", in_ready, out_pc); end
        out_ready = 1'b1;
        pending = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            if (pending) in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                got = exp_q.pop_front();
                checks++; if (out_pc !== got) begin failures++; $display("FAIL b2b_order got=%h exp=%h", out_pc, got); end
            end
            if (in_valid && in_ready) pending = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_timeout left=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'hA0;
        @(negedge clk);
        in_pc = 32'hB0;
        @(negedge clk);
        in_pc = 32'hC0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || dut.count !== '0) begin failures++; $display("FAIL flush_full v=%b count=%0d exp=0,0", out_valid, dut.count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1; in_pc = 32'hD0;
        @(negedge clk);
        in_pc = 32'hE0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_push_ignored v=%b exp=0", out_valid); end
        out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'hF0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hF0) begin failures++; $display("FAIL flush_after v=%b pc=%h exp=1,f0", out_valid, out_pc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h300;
        @(negedge clk);
        in_pc = 32'h304;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL arst_now v=%b rdy=%b exp=0,0", out_valid, in_ready); end
        checks++; if (out_pc !== '0 || out_rd !== 5'd0) begin failures++; $display("FAIL arst_fields pc=%h rd=%0d exp=0,0", out_pc, out_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL arst_release rdy=%b v=%b exp=1,0", in_ready, out_valid); end
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h400; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin failures++; $display("FAIL nop_latency v=%b pc=%h exp=1,400", out_valid, out_pc); end
        checks++; if (out_is_illegal !== 1'b0 || out_is_writeback !== 1'b0 || out_imm !== '0) begin failures++; $display("FAIL nop_fields ill=%b wb=%b imm=%h exp=0,0,0", out_is_illegal, out_is_writeback, out_imm); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store_branch();
        test_upper_jump();
        test_muldiv();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
